des_key_sched: RTL and testbench

Sequential DES key-schedule generator that sits directly upstream of the DES round datapath. It accepts a 64-bit key and a direction flag, applies PC-1, rotates the C/D halves per round, and streams the 16 PC-2 subkeys one per handshake. In encrypt mode it emits K1..K16; in decrypt mode it emits K16..K1. The consuming round engine takes one subkey per round and never recomputes the schedule itself.

---
 rtl/des_key_sched.sv | 211 +++++++++++++++++++++
 tb/tb_des_key_sched.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched.sv
// -----------------------------------------------------------------------------
// des_key_sched
//
// Sequential DES key-schedule generator. Accepts a 64-bit key plus a direction
// flag, applies PC-1, and streams the 16 PC-2 subkeys one per handshake:
// K1..K16 when encrypting, K16..K1 when decrypting.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. valid never depends on ready. Once sk_valid is high, sk / sk_round /
// sk_last stay stable until the transfer happens.
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   key_valid  in   1  key/decrypt offered
//   key_ready  out  1  block idle, can accept a key
//   key        in  64  DES key, key[63] is DES bit 1
//   decrypt    in   1  0: K1..K16, 1: K16..K1 (sampled with the key)
//   sk_valid   out  1  sk holds a subkey
//   sk_ready   in   1  consumer takes sk this cycle
//   sk         out 48  PC-2 subkey, sk[47] is PC-2 bit 1
//   sk_round   out  4  emission index 0..15
//   sk_last    out  1  high with the 16th subkey
//   busy       out  1  high while emitting (this is also the FSM state bit)
//   parity_err out  1  odd-parity violation on the last accepted key
//
// Build option:
//   DES_KEY_PARITY_CHECK_EN  when defined, parity_err registers 1 at the accept
//                            edge if any key byte has even parity. When not
//                            defined, parity_err is tied to 0.
// -----------------------------------------------------------------------------
module des_key_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [63:0] key,
    input  logic        decrypt,
    output logic        sk_valid,
    input  logic        sk_ready,
    output logic [47:0] sk,
    output logic [3:0]  sk_round,
    output logic        sk_last,
    output logic        busy,
    output logic        parity_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // FIPS 46-3 permutation tables, 1-based DES bit numbers.
    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    // DES bit n of a 64-bit key lives at key[64-n]; result bit 1 at [55].
    function automatic logic [55:0] pc1_perm(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1[i])];
        end
        return r;
    endfunction

    // cd = {C, D}; DES bit n of CD lives at cd[56-n].
    function automatic logic [47:0] pc2_perm(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2[i])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic [27:0] c_q;
    logic [27:0] d_q;
    logic [3:0]  cnt;
    logic        dir;

    logic        accept;
    logic        sk_fire;
    logic        advance;
    logic        finish;
    logic [55:0] cd0;
    logic [27:0] c_first;
    logic [27:0] d_first;
    logic [3:0]  next_n;
    logic        step_two;
    logic [27:0] c_step;
    logic [27:0] d_step;

    assign accept  = key_valid && key_ready;
    assign sk_fire = sk_valid && sk_ready;
    assign advance = sk_fire && (cnt != 4'd15);
    assign finish  = sk_fire && (cnt == 4'd15);

    // First emission: K1 needs one left shift; K16 is C0/D0 unshifted because
    // the encrypt shifts sum to a full 28-position turn.
    assign cd0     = pc1_perm(key);
    assign c_first = decrypt ? cd0[55:28] : rot_left(cd0[55:28], 1'b0);
    assign d_first = decrypt ? cd0[27:0]  : rot_left(cd0[27:0],  1'b0);

    // Shift amount for emission n >= 1 is the same in both directions
    // (1 at n = 1, 8, 15, otherwise 2); only the rotation direction differs.
    assign next_n   = cnt + 4'd1;
    assign step_two = !((next_n == 4'd1) || (next_n == 4'd8) || (next_n == 4'd15));
    assign c_step   = dir ? rot_right(c_q, step_two) : rot_left(c_q, step_two);
    assign d_step   = dir ? rot_right(d_q, step_two) : rot_left(d_q, step_two);

    // ---------------------------------------------------------------- FSM: state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------------------------------------------------- FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_EMIT;
            S_EMIT:  if (finish) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- FSM: outputs
    always_comb begin
        key_ready = (state == S_IDLE);
        sk_valid  = (state == S_EMIT);
        busy      = (state == S_EMIT);
        sk_last   = (state == S_EMIT) && (cnt == 4'd15);
        sk_round  = cnt;
    end

    // ------------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q <= '0;
            d_q <= '0;
            sk  <= '0;
            cnt <= '0;
            dir <= 1'b0;
        end else if (accept) begin
            dir <= decrypt;
            c_q <= c_first;
            d_q <= d_first;
            sk  <= pc2_perm({c_first, d_first});
            cnt <= 4'd0;
        end else if (advance) begin
            c_q <= c_step;
            d_q <= d_step;
            sk  <= pc2_perm({c_step, d_step});
            cnt <= next_n;
        end else if (finish) begin
            // Park the index at 0 so sk_round reads 0 while idle.
            cnt <= 4'd0;
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // DES keys carry odd parity per byte; an even-parity byte is an error.
    logic parity_q;
    logic key_par_bad;

    always_comb begin
        key_par_bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (!(^key[b*8 +: 8])) key_par_bad = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= key_par_bad;
        end
    end

    assign parity_err = parity_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_key_sched.sv
// -----------------------------------------------------------------------------
// tb_des_key_sched
//
// Self-checking bench for des_key_sched. Inputs are driven and outputs sampled
// on the falling clock edge. Expected subkeys come from a reference model that
// computes each key number directly from its cumulative shift count.
// -----------------------------------------------------------------------------
module tb_des_key_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        sk_valid;
    logic        sk_ready = 1'b0;
    logic [47:0] sk;
    logic [3:0]  sk_round;
    logic        sk_last;
    logic        busy;
    logic        parity_err;

    localparam logic [63:0] VEC_KEY   = 64'h133457799BBCDFF1;
    localparam logic [63:0] BUSY_KEY  = 64'h0123456789ABCDEF;
    localparam logic [47:0] VEC_K1    = 48'h1B02EFFC7072;
    localparam logic [47:0] VEC_K2    = 48'h79AED9DBC9E5;
    localparam logic [47:0] VEC_K16   = 48'hCB3D8B0E17F5;

`ifdef DES_KEY_PARITY_CHECK_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };
    localparam int M_SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    int          n_compared = 0;
    int          n_mismatched = 0;
    logic [47:0] exp_q[$];
    logic [47:0] got_sk [16];

    des_key_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key        (key),
        .decrypt    (decrypt),
        .sk_valid   (sk_valid),
        .sk_ready   (sk_ready),
        .sk         (sk),
        .sk_round   (sk_round),
        .sk_last    (sk_last),
        .busy       (busy),
        .parity_err (parity_err)
    );

    // ------------------------------------------------------------ clock / reset
    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n     = 1'b0;
        key_valid = 1'b0;
        sk_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------------------------------------------------- reference model
    // Key number kn (1..16): C/D rotated left by the sum of the first kn shifts.
    function automatic logic [47:0] model_subkey(input logic [63:0] k, input int kn);
        logic [1:64] kb;
        logic [1:56] cd0;
        logic [1:56] cd;
        logic [1:48] o;
        int tot;
        kb  = k;
        tot = 0;
        for (int i = 1; i <= 56; i++) cd0[i] = kb[M_PC1[i-1]];
        for (int r = 0; r < kn; r++) tot += M_SHIFTS[r];
        for (int i = 1; i <= 28; i++) begin
            cd[i]      = cd0[((i - 1 + tot) % 28) + 1];
            cd[28 + i] = cd0[28 + ((i - 1 + tot) % 28) + 1];
        end
        for (int i = 1; i <= 48; i++) o[i] = cd[M_PC2[i-1]];
        return o;
    endfunction

    function automatic bit model_parity(input logic [63:0] k);
        int ones;
        bit bad;
        bad = 1'b0;
        for (int b = 0; b < 8; b++) begin
            ones = 0;
            for (int j = 0; j < 8; j++) ones += int'(k[b*8 + j]);
            if (ones % 2 == 0) bad = 1'b1;
        end
        return PAR_EN ? bad : 1'b0;
    endfunction

    task automatic model_fill(input logic [63:0] k, input logic dec);
        exp_q.delete();
        for (int e = 0; e < 16; e++) begin
            exp_q.push_back(model_subkey(k, dec ? (16 - e) : (e + 1)));
        end
    endtask

    // ------------------------------------------------------------ driver tasks
    // Called on a falling edge; offers the key for one rising edge.
    task automatic accept_key(input logic [63:0] k, input logic dec);
        key       = k;
        decrypt   = dec;
        key_valid = 1'b1;
        n_compared++;
        if (key_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL accept_key_ready: got %b expected 1", key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key       = {$urandom, $urandom};
        decrypt   = 1'($urandom_range(1));
        n_compared++;
        if (parity_err !== model_parity(k)) begin
            n_mismatched++;
            $display("FAIL parity_err: got %b expected %b", parity_err, model_parity(k));
        end
    endtask

    // Consumes stop_after subkeys, sk_ready low with probability bp_pct percent.
    // While offer_at <= handshakes < offer_at+3 a competing key is offered.
    task automatic run_stream(input int bp_pct, input int stop_after, input int offer_at);
        int          hs;
        int          cyc;
        bit          stalled;
        logic [47:0] held;
        logic [47:0] exp;
        hs      = 0;
        cyc     = 0;
        stalled = 1'b0;
        held    = '0;
        while (hs < stop_after && cyc < 400) begin
            n_compared++;
            if (sk_valid !== 1'b1) begin
                n_mismatched++;
                $display("FAIL stream_valid: got %b expected 1 at handshake %0d", sk_valid, hs);
            end else begin
                n_compared++;
                if (stalled && sk !== held) begin
                    n_mismatched++;
                    $display("FAIL stall_hold: got %h expected %h", sk, held);
                end
                n_compared++;
                if (sk_round !== 4'(hs) || sk_last !== (hs == 15) || busy !== 1'b1 || key_ready !== 1'b0) begin
                    n_mismatched++;
                    $display("FAIL stream_flags: got round=%0d last=%b busy=%b kr=%b expected round=%0d last=%b busy=1 kr=0",
                             sk_round, sk_last, busy, key_ready, hs, (hs == 15));
                end
                if (offer_at >= 0 && hs >= offer_at && hs < offer_at + 3) begin
                    key_valid = 1'b1;
                    key       = BUSY_KEY;
                    decrypt   = 1'b0;
                end else begin
                    key_valid = 1'b0;
                end
                sk_ready = (int'($urandom_range(99)) >= bp_pct);
                if (sk_ready) begin
                    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 48'hx;
                    got_sk[hs] = sk;
                    n_compared++;
                    if (sk !== exp) begin
                        n_mismatched++;
                        $display("FAIL subkey[%0d]: got %h expected %h", hs, sk, exp);
                    end
                    hs++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = sk;
                end
            end
            cyc++;
            @(negedge clk);
        end
        sk_ready  = 1'b0;
        key_valid = 1'b0;
        n_compared++;
        if (hs < stop_after) begin
            n_mismatched++;
            $display("FAIL stream_timeout: got %0d handshakes expected %0d", hs, stop_after);
        end
        if (bp_pct == 0) begin
            n_compared++;
            if (cyc != stop_after) begin
                n_mismatched++;
                $display("FAIL stream_cycles: got %0d expected %0d", cyc, stop_after);
            end
        end
        if (stop_after == 16) begin
            n_compared++;
            if (key_ready !== 1'b1 || sk_valid !== 1'b0 || busy !== 1'b0 || sk_last !== 1'b0) begin
                n_mismatched++;
                $display("FAIL stream_end_idle: got kr=%b v=%b busy=%b last=%b expected 1 0 0 0",
                         key_ready, sk_valid, busy, sk_last);
            end
        end
    endtask

    // ------------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (key_ready !== 1'b1 || sk_valid !== 1'b0 || sk !== 48'h0 || sk_round !== 4'd0 ||
            sk_last !== 1'b0 || busy !== 1'b0 || parity_err !== 1'b0) begin
            n_mismatched++;
            $display("FAIL reset_state: got kr=%b v=%b sk=%h rnd=%0d last=%b busy=%b perr=%b expected 1 0 0 0 0 0 0",
                     key_ready, sk_valid, sk, sk_round, sk_last, busy, parity_err);
        end
        apply_reset();
    endtask

    task automatic test_encrypt_vector();
        accept_key(VEC_KEY, 1'b0);
        model_fill(VEC_KEY, 1'b0);
        run_stream(0, 16, -1);
        n_compared++;
        if (got_sk[0] !== VEC_K1 || got_sk[1] !== VEC_K2 || got_sk[15] !== VEC_K16) begin
            n_mismatched++;
            $display("FAIL enc_vector: got %h %h %h expected %h %h %h",
                     got_sk[0], got_sk[1], got_sk[15], VEC_K1, VEC_K2, VEC_K16);
        end
    endtask

    task automatic test_decrypt_vector();
        accept_key(VEC_KEY, 1'b1);
        model_fill(VEC_KEY, 1'b1);
        run_stream(0, 16, -1);
        n_compared++;
        if (got_sk[0] !== VEC_K16 || got_sk[14] !== VEC_K2 || got_sk[15] !== VEC_K1) begin
            n_mismatched++;
            $display("FAIL dec_vector: got %h %h %h expected %h %h %h",
                     got_sk[0], got_sk[14], got_sk[15], VEC_K16, VEC_K2, VEC_K1);
        end
    endtask

    task automatic test_backpressure();
        accept_key(VEC_KEY, 1'b0);
        model_fill(VEC_KEY, 1'b0);
        run_stream(50, 16, -1);
    endtask

    task automatic test_busy_rejection();
        accept_key(VEC_KEY, 1'b0);
        model_fill(VEC_KEY, 1'b0);
        run_stream(0, 16, 3);
        @(negedge clk);
        n_compared++;
        if (sk_valid !== 1'b0 || key_ready !== 1'b1) begin
            n_mismatched++;
            $display("FAIL busy_reject_idle: got v=%b kr=%b expected 0 1", sk_valid, key_ready);
        end
    endtask

    task automatic test_async_reset();
        accept_key(VEC_KEY, 1'b0);
        model_fill(VEC_KEY, 1'b0);
        run_stream(0, 6, -1);
        #2;
        rst_n = 1'b0;
        #1;
        n_compared++;
        if (sk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || sk !== 48'h0 ||
            sk_round !== 4'd0 || sk_last !== 1'b0) begin
            n_mismatched++;
            $display("FAIL async_reset: got v=%b busy=%b kr=%b sk=%h rnd=%0d last=%b expected 0 0 1 0 0 0",
                     sk_valid, busy, key_ready, sk, sk_round, sk_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sk_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if (sk_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL post_reset_quiet: got %b expected 0", sk_valid);
        end
        sk_ready = 1'b0;
        accept_key(VEC_KEY, 1'b0);
        model_fill(VEC_KEY, 1'b0);
        run_stream(0, 16, -1);
        n_compared++;
        if (got_sk[0] !== VEC_K1) begin
            n_mismatched++;
            $display("FAIL restart_first: got %h expected %h", got_sk[0], VEC_K1);
        end
    endtask

    task automatic test_parity();
        accept_key(64'h0, 1'b0);
        model_fill(64'h0, 1'b0);
        run_stream(0, 16, -1);
        n_compared++;
        if (got_sk[0] !== 48'h0 || got_sk[7] !== 48'h0 || got_sk[15] !== 48'h0) begin
            n_mismatched++;
            $display("FAIL zero_key: got %h %h %h expected 0", got_sk[0], got_sk[7], got_sk[15]);
        end
        n_compared++;
        if (parity_err !== model_parity(64'h0)) begin
            n_mismatched++;
            $display("FAIL parity_hold: got %b expected %b", parity_err, model_parity(64'h0));
        end
        accept_key(VEC_KEY, 1'b1);
        model_fill(VEC_KEY, 1'b1);
        run_stream(20, 16, -1);
    endtask

    task automatic test_random();
        logic [63:0] k;
        logic        d;
        for (int t = 0; t < 8; t++) begin
            k = {$urandom, $urandom};
            d = 1'($urandom_range(1));
            repeat ($urandom_range(3)) @(negedge clk);
            accept_key(k, d);
            model_fill(k, d);
            run_stream(int'($urandom_range(60)), 16, -1);
        end
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        test_reset();
        test_encrypt_vector();
        test_decrypt_vector();
        test_backpressure();
        test_busy_rejection();
        test_async_reset();
        test_parity();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
